regfile_2r2w: RTL and testbench

Parametrised register file with two registered read ports, two write ports and same-cycle write-to-read forwarding. Both read ports have an immediate mode that returns the zero-extended pointer instead of register contents. The ALU writeback drives write port W; the memory load return drives port L. Reads feed the two datapath operand buses.

---
 rtl/regfile_2r2w.sv | 88 ++++++++
 tb/tb_regfile_2r2w.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r2w.sv
// rtl/regfile_2r2w.sv - two-read/two-write register file with write-to-read forwarding
// Port L (load return) outranks port W (ALU) for both storage and forwarding.
module regfile_2r2w #(
  parameter int DATA_WIDTH    = 8,
  parameter int POINTER_WIDTH = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [POINTER_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     load_enable,
  input  logic [POINTER_WIDTH-1:0] load_address,
  input  logic [DATA_WIDTH-1:0]    load_data,
  input  logic [POINTER_WIDTH-1:0] address_a,
  input  logic [POINTER_WIDTH-1:0] address_b,
  input  logic                     is_immediate_a,
  input  logic                     is_immediate_b,
  output logic [DATA_WIDTH-1:0]    data_out_a,
  output logic [DATA_WIDTH-1:0]    data_out_b,
  output logic                     write_collision
);

  localparam int DEPTH = 2 ** POINTER_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic                  collision_q, collision_d;

  // Read-port selection mirrors the write priority so forwarded data equals the post-edge contents.
  function automatic logic [DATA_WIDTH-1:0] read_select(
    input logic                     imm,
    input logic [POINTER_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0]    stored
  );
    logic [DATA_WIDTH-1:0] value;
    value = '0;
    if (imm) begin
      value[POINTER_WIDTH-1:0] = addr;
    end else if (load_enable && (load_address == addr)) begin
      value = load_data;
    end else if (write_enable && (write_address == addr)) begin
      value = write_data;
    end else begin
      value = stored;
    end
    return value;
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (write_enable) begin
      regs_d[write_address] = write_data;
    end
    if (load_enable) begin
      regs_d[load_address] = load_data;
    end
  end

  always_comb begin
    data_a_d    = read_select(is_immediate_a, address_a, regs_q[address_a]);
    data_b_d    = read_select(is_immediate_b, address_b, regs_q[address_b]);
    collision_d = write_enable && load_enable && (write_address == load_address);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      data_a_q    <= '0;
      data_b_q    <= '0;
      collision_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      collision_q <= collision_d;
    end
  end

  assign data_out_a      = data_a_q;
  assign data_out_b      = data_b_q;
  assign write_collision = collision_q;

endmodule

// File: tb/tb_regfile_2r2w.sv
// tb/tb_regfile_2r2w.sv - directed and random checks of regfile_2r2w at two sizes
module tb_regfile_2r2w;

  logic clock, reset;

  logic       we8, le8, ia8, ib8, col8;
  logic [2:0] wa8, la8, aa8, ab8;
  logic [7:0] wd8, ld8, da8, db8;

  logic        we16, le16, ia16, ib16, col16;
  logic [4:0]  wa16, la16, aa16, ab16;
  logic [15:0] wd16, ld16, da16, db16;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m8  [8];
  logic [15:0] m16 [32];

  regfile_2r2w dut8 (
    .clock(clock), .reset(reset),
    .write_enable(we8), .write_address(wa8), .write_data(wd8),
    .load_enable(le8), .load_address(la8), .load_data(ld8),
    .address_a(aa8), .address_b(ab8),
    .is_immediate_a(ia8), .is_immediate_b(ib8),
    .data_out_a(da8), .data_out_b(db8), .write_collision(col8)
  );

  regfile_2r2w #(.DATA_WIDTH(16), .POINTER_WIDTH(5)) dut16 (
    .clock(clock), .reset(reset),
    .write_enable(we16), .write_address(wa16), .write_data(wd16),
    .load_enable(le16), .load_address(la16), .load_data(ld16),
    .address_a(aa16), .address_b(ab16),
    .is_immediate_a(ia16), .is_immediate_b(ib16),
    .data_out_a(da16), .data_out_b(db16), .write_collision(col16)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we8 = 0; le8 = 0; ia8 = 0; ib8 = 0;
    wa8 = 0; la8 = 0; aa8 = 0; ab8 = 0; wd8 = 0; ld8 = 0;
    we16 = 0; le16 = 0; ia16 = 0; ib16 = 0;
    wa16 = 0; la16 = 0; aa16 = 0; ab16 = 0; wd16 = 0; ld16 = 0;
  endtask

  // A read returns whatever the register holds once this edge's writes (L last) have landed.
  task automatic tick();
    logic [7:0]  p8  [8];
    logic [15:0] p16 [32];
    logic [7:0]  ea8, eb8;
    logic [15:0] ea16, eb16;
    logic        ec8, ec16;
    if (reset) begin
      foreach (m8[i])  m8[i]  = '0;
      foreach (m16[i]) m16[i] = '0;
      ea8 = 0; eb8 = 0; ec8 = 0; ea16 = 0; eb16 = 0; ec16 = 0;
    end else begin
      p8 = m8;
      if (we8) p8[wa8] = wd8;
      if (le8) p8[la8] = ld8;
      ea8 = ia8 ? {5'b0, aa8} : p8[aa8];
      eb8 = ib8 ? {5'b0, ab8} : p8[ab8];
      ec8 = we8 && le8 && (wa8 == la8);
      m8 = p8;
      p16 = m16;
      if (we16) p16[wa16] = wd16;
      if (le16) p16[la16] = ld16;
      ea16 = ia16 ? {11'b0, aa16} : p16[aa16];
      eb16 = ib16 ? {11'b0, ab16} : p16[ab16];
      ec16 = we16 && le16 && (wa16 == la16);
      m16 = p16;
    end
    @(posedge clock);
    #1;
    chk("model_a8", {8'b0, da8}, {8'b0, ea8});
    chk("model_b8", {8'b0, db8}, {8'b0, eb8});
    chk("model_col8", {15'b0, col8}, {15'b0, ec8});
    chk("model_a16", da16, ea16);
    chk("model_b16", db16, eb16);
    chk("model_col16", {15'b0, col16}, {15'b0, ec16});
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("por_a", {8'b0, da8}, 16'h0);
    chk("por_b", {8'b0, db8}, 16'h0);
    chk("por_col", {15'b0, col8}, 16'h0);
    we8 = 1; wa8 = 1; wd8 = 8'hEE; aa8 = 1;
    tick();
    idle();
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      we8 = 1; wa8 = 3'(i); wd8 = 8'(7 - i); aa8 = 3'(i); ab8 = 3'(7 - i);
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      aa8 = 3'(i); ab8 = 3'(7 - i);
      tick();
      chk("fill_a", {8'b0, da8}, 16'(7 - i));
      chk("fill_b", {8'b0, db8}, 16'(i));
    end

    we8 = 1; wa8 = 3; wd8 = 8'h11;
    tick();
    wd8 = 8'h5A; aa8 = 3;
    tick();
    chk("fwd_w", {8'b0, da8}, 16'h005A);
    we8 = 0; le8 = 1; la8 = 3; ld8 = 8'hC3;
    tick();
    chk("fwd_l", {8'b0, da8}, 16'h00C3);

    idle();
    we8 = 1; wa8 = 2; wd8 = 8'hAA; le8 = 1; la8 = 2; ld8 = 8'h55; ab8 = 2;
    tick();
    chk("coll_b", {8'b0, db8}, 16'h0055);
    chk("coll_flag", {15'b0, col8}, 16'h1);
    idle();
    aa8 = 2;
    tick();
    chk("coll_clear", {15'b0, col8}, 16'h0);
    chk("coll_readback", {8'b0, da8}, 16'h0055);
    we8 = 1; wa8 = 1; wd8 = 8'h21; le8 = 1; la8 = 4; ld8 = 8'h44;
    tick();
    chk("nocoll_flag", {15'b0, col8}, 16'h0);
    idle();
    aa8 = 1; ab8 = 4;
    tick();
    chk("nocoll_w", {8'b0, da8}, 16'h0021);
    chk("nocoll_l", {8'b0, db8}, 16'h0044);

    we8 = 1; wa8 = 5; wd8 = 8'h99;
    tick();
    wd8 = 8'h77; ia8 = 1; aa8 = 5;
    tick();
    chk("imm8", {8'b0, da8}, 16'h0005);
    idle();
    ia16 = 1; aa16 = 5'hF; ib16 = 1; ab16 = 5'h1F;
    tick();
    chk("imm16_f", da16, 16'h000F);
    chk("imm16_1f", db16, 16'h001F);

    idle();
    we8 = 1; wa8 = 6; le8 = 1; la8 = 6; wd8 = 8'h01; ld8 = 8'h02; aa8 = 6; ab8 = 6;
    tick();
    reset = 1'b1;
    #2;
    chk("midrst_a", {8'b0, da8}, 16'h0);
    chk("midrst_b", {8'b0, db8}, 16'h0);
    chk("midrst_col", {15'b0, col8}, 16'h0);
    tick();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) begin
      aa8 = 3'(i); ab8 = 3'(i);
      tick();
      chk("rst_read", {8'b0, da8}, 16'h0);
    end

    idle();
    for (int i = 0; i < 32; i++) begin
      we16 = 1; wa16 = 5'(i); wd16 = 16'(16'h1000 + i);
      tick();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      aa16 = 5'(i); ab16 = 5'(31 - i);
      tick();
      chk("depth_a", da16, 16'(16'h1000 + i));
      chk("depth_b", db16, 16'(16'h1000 + 31 - i));
    end

    for (int n = 0; n < 400; n++) begin
      we8 = 1'($urandom_range(0, 1)); le8 = 1'($urandom_range(0, 1));
      wa8 = 3'($urandom_range(0, 7)); la8 = 3'($urandom_range(0, 3));
      wd8 = 8'($urandom); ld8 = 8'($urandom);
      aa8 = 3'($urandom_range(0, 7)); ab8 = 3'($urandom_range(0, 7));
      ia8 = ($urandom_range(0, 5) == 0); ib8 = ($urandom_range(0, 5) == 0);
      we16 = 1'($urandom_range(0, 1)); le16 = 1'($urandom_range(0, 1));
      wa16 = 5'($urandom_range(0, 31)); la16 = 5'($urandom_range(0, 7));
      wd16 = 16'($urandom); ld16 = 16'($urandom);
      aa16 = 5'($urandom_range(0, 31)); ab16 = 5'($urandom_range(0, 7));
      ia16 = ($urandom_range(0, 5) == 0); ib16 = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
